// File: rtl/ravenoc_pkg.sv
// Shared types and width helpers for the router input datapath: flit types,
// arbiter FSM states and the VC-id / occupancy width functions.
package ravenoc_pkg;

    typedef enum logic [1:0] {
        FLIT_HEAD      = 2'd0,
        FLIT_BODY      = 2'd1,
        FLIT_TAIL      = 2'd2,
        FLIT_HEAD_TAIL = 2'd3
    } flit_type_e;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_LOCK = 1'b1
    } arb_state_e;

    function automatic int vc_width(input int num_vc);
        return (num_vc > 1) ? $clog2(num_vc) : 1;
    endfunction

    function automatic int occ_width(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vc_circ_fifo.sv
// Single virtual-channel circular FIFO with wrap-around pointers and an
// up/down occupancy counter. Depth must be a power of two (>= 2).
module vc_circ_fifo #(
    parameter int Depth = 4,
    parameter int Width = 36,
    localparam int PtrW = $clog2(Depth),
    localparam int OccW = $clog2(Depth + 1)
) (
    input  logic            clk,
    input  logic            arst,
    input  logic            push,
    input  logic            pop,
    input  logic [Width-1:0] wdata,
    output logic [Width-1:0] rdata,
    output logic            full,
    output logic            empty,
    output logic [OccW-1:0] occ
);

    logic [Width-1:0] mem_r [Depth];
    logic [PtrW-1:0]  wr_ptr_r;
    logic [PtrW-1:0]  rd_ptr_r;
    logic [OccW-1:0]  occ_r;
    logic             full_s;
    logic             empty_s;
    logic             do_push_s;
    logic             do_pop_s;

    // Status flags and guarded push/pop strobes
    always_comb begin
        full_s    = (occ_r == OccW'(Depth));
        empty_s   = (occ_r == {OccW{1'b0}});
        do_push_s = push & ~full_s;
        do_pop_s  = pop & ~empty_s;
    end

    // Pointer and occupancy state
    always_ff @(posedge clk) begin
        if (arst) begin
            wr_ptr_r <= {PtrW{1'b0}};
            rd_ptr_r <= {PtrW{1'b0}};
            occ_r    <= {OccW{1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PtrW'(1);
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PtrW'(1);
            case ({do_push_s, do_pop_s})
                2'b10:   occ_r <= occ_r + OccW'(1);
                2'b01:   occ_r <= occ_r - OccW'(1);
                default: occ_r <= occ_r;
            endcase
        end
    end

    // Payload storage; contents need no reset since occupancy gates visibility
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r] <= wdata;
    end

    assign rdata = mem_r[rd_ptr_r];
    assign full  = full_s;
    assign empty = empty_s;
    assign occ   = occ_r;

endmodule

// File: rtl/vc_input_datapath_pkt.sv
// Router input datapath: VC demux into per-VC FIFOs, packet/flit arbiter and
// output mux. Define RAVENOC_RR_ARB_EN for round-robin instead of fixed priority.
module vc_input_datapath_pkt
    import ravenoc_pkg::*;
#(
    parameter int NumVc        = 3,
    parameter int VcDepth      = 4,
    parameter int FlitWidth    = 34,
    parameter int PktArb       = 1,
    parameter int HighPrioZero = 1,
    localparam int VcW         = vc_width(NumVc),
    localparam int OccW        = occ_width(VcDepth)
) (
    input  logic                  clk,
    input  logic                  arst,
    input  logic [FlitWidth-1:0]  fin_fdata_i,
    input  logic [1:0]            fin_type_i,
    input  logic [VcW-1:0]        fin_vc_i,
    input  logic                  fin_valid_i,
    output logic                  fin_ready_o,
    output logic [FlitWidth-1:0]  fout_fdata_o,
    output logic [1:0]            fout_type_o,
    output logic [VcW-1:0]        fout_vc_o,
    output logic                  fout_valid_o,
    input  logic                  fout_ready_i,
    output logic [NumVc-1:0]      full_o,
    output logic [NumVc-1:0]      empty_o,
    output logic [NumVc*OccW-1:0] occ_o,
    output logic                  err_o
);

    localparam int PadVc = 1 << VcW;
    localparam int EntW  = FlitWidth + 2;

    logic [NumVc-1:0] full_s;
    logic [NumVc-1:0] empty_s;
    logic [NumVc-1:0] push_s;
    logic [NumVc-1:0] pop_s;
    logic [PadVc-1:0] full_pad_s;
    logic [PadVc-1:0] nonempty_pad_s;
    logic [EntW-1:0]  rdata_pad_s [PadVc];
    logic [EntW-1:0]  head_ent_s;
    logic [VcW-1:0]   win_s;
    logic [VcW-1:0]   sel_s;
    logic             vc_legal_s;
    logic             fin_ready_s;
    logic             fout_valid_s;
    logic             handshake_s;
    logic [1:0]       out_type_s;

    arb_state_e       state_r;
    logic [VcW-1:0]   gnt_r;
    logic             hold_r;
    logic             err_r;
`ifdef RAVENOC_RR_ARB_EN
    logic [VcW-1:0]   rr_ptr_r;
    int               rr_idx_s;
`endif

    // Input acceptance: illegal VC ids are always accepted (and dropped)
    always_comb begin
        vc_legal_s = (int'(fin_vc_i) < NumVc);
        if (fin_valid_i && vc_legal_s) begin
            fin_ready_s = ~full_pad_s[fin_vc_i];
        end else begin
            fin_ready_s = 1'b1;
        end
    end

    for (genvar i = 0; i < NumVc; i++) begin : g_vc
        logic [EntW-1:0] rdata_s;
        logic [OccW-1:0] occ_s;

        assign push_s[i] = fin_valid_i & fin_ready_s & vc_legal_s & (fin_vc_i == VcW'(i));
        assign pop_s[i]  = handshake_s & (sel_s == VcW'(i));

        vc_circ_fifo #(
            .Depth (VcDepth),
            .Width (EntW)
        ) u_fifo (
            .clk   (clk),
            .arst  (arst),
            .push  (push_s[i]),
            .pop   (pop_s[i]),
            .wdata ({fin_type_i, fin_fdata_i}),
            .rdata (rdata_s),
            .full  (full_s[i]),
            .empty (empty_s[i]),
            .occ   (occ_s)
        );

        assign full_pad_s[i]            = full_s[i];
        assign nonempty_pad_s[i]        = ~empty_s[i];
        assign rdata_pad_s[i]           = rdata_s;
        assign occ_o[i*OccW +: OccW]    = occ_s;
    end

    // Unused VC-id codes look permanently empty and never full
    for (genvar j = NumVc; j < PadVc; j++) begin : g_pad
        assign full_pad_s[j]     = 1'b0;
        assign nonempty_pad_s[j] = 1'b0;
        assign rdata_pad_s[j]    = {EntW{1'b0}};
    end

    // Arbitration among non-empty VCs; the last hit in each loop has priority
    always_comb begin
        win_s = {VcW{1'b0}};
`ifdef RAVENOC_RR_ARB_EN
        rr_idx_s = 0;
        for (int k = NumVc - 1; k >= 0; k--) begin
            rr_idx_s = int'(rr_ptr_r) + k;
            if (rr_idx_s >= NumVc) begin
                rr_idx_s = rr_idx_s - NumVc;
            end else begin
                rr_idx_s = rr_idx_s;
            end
            if (nonempty_pad_s[VcW'(rr_idx_s)]) begin
                win_s = VcW'(rr_idx_s);
            end else begin
                win_s = win_s;
            end
        end
`else
        if (HighPrioZero != 0) begin
            for (int i = NumVc - 1; i >= 0; i--) begin
                if (nonempty_pad_s[VcW'(i)]) win_s = VcW'(i);
                else                         win_s = win_s;
            end
        end else begin
            for (int i = 0; i < NumVc; i++) begin
                if (nonempty_pad_s[VcW'(i)]) win_s = VcW'(i);
                else                         win_s = win_s;
            end
        end
`endif
    end

    // Output selection: a lock or a stalled presentation pins the grant
    always_comb begin
        if ((state_r == ARB_LOCK) || hold_r) begin
            sel_s = gnt_r;
        end else begin
            sel_s = win_s;
        end
        case (state_r)
            ARB_LOCK: fout_valid_s = nonempty_pad_s[gnt_r];
            ARB_IDLE: fout_valid_s = hold_r | (|nonempty_pad_s);
            default:  fout_valid_s = 1'b0;
        endcase
        handshake_s = fout_valid_s & fout_ready_i;
        head_ent_s  = rdata_pad_s[sel_s];
        out_type_s  = head_ent_s[EntW-1:FlitWidth];
    end

    // Arbiter FSM, grant/hold registers, round-robin pointer and sticky error
    always_ff @(posedge clk) begin
        if (arst) begin
            state_r  <= ARB_IDLE;
            gnt_r    <= {VcW{1'b0}};
            hold_r   <= 1'b0;
            err_r    <= 1'b0;
`ifdef RAVENOC_RR_ARB_EN
            rr_ptr_r <= {VcW{1'b0}};
`endif
        end else begin
            err_r  <= err_r | (fin_valid_i & ~vc_legal_s);
            hold_r <= fout_valid_s & ~fout_ready_i;
            if (fout_valid_s) gnt_r <= sel_s;
            case (state_r)
                ARB_IDLE: begin
                    if (handshake_s && (PktArb != 0) && (out_type_s == FLIT_HEAD)) begin
                        state_r <= ARB_LOCK;
                    end
                end
                ARB_LOCK: begin
                    if (handshake_s && ((out_type_s == FLIT_TAIL) || (out_type_s == FLIT_HEAD_TAIL))) begin
                        state_r <= ARB_IDLE;
                    end
                end
                default: state_r <= ARB_IDLE;
            endcase
`ifdef RAVENOC_RR_ARB_EN
            if ((state_r == ARB_IDLE) && handshake_s) begin
                rr_ptr_r <= (sel_s == VcW'(NumVc - 1)) ? {VcW{1'b0}} : sel_s + VcW'(1);
            end
`endif
        end
    end

    assign fin_ready_o  = fin_ready_s;
    assign fout_fdata_o = head_ent_s[FlitWidth-1:0];
    assign fout_type_o  = out_type_s;
    assign fout_vc_o    = sel_s;
    assign fout_valid_o = fout_valid_s;
    assign full_o       = full_s;
    assign empty_o      = empty_s;
    assign err_o        = err_r;

endmodule

// File: tb/tb_vc_input_datapath_pkt.sv
// Directed self-checking bench for vc_input_datapath_pkt (default parameters).
module tb_vc_input_datapath_pkt;

    localparam logic [1:0] T_HEAD = 2'd0;
    localparam logic [1:0] T_BODY = 2'd1;
    localparam logic [1:0] T_TAIL = 2'd2;
    localparam logic [1:0] T_HT   = 2'd3;

    logic        clk = 1'b0;
    logic        arst;
    logic [33:0] fin_fdata_i;
    logic [1:0]  fin_type_i;
    logic [1:0]  fin_vc_i;
    logic        fin_valid_i;
    logic        fin_ready_o;
    logic [33:0] fout_fdata_o;
    logic [1:0]  fout_type_o;
    logic [1:0]  fout_vc_o;
    logic        fout_valid_o;
    logic        fout_ready_i;
    logic [2:0]  full_o;
    logic [2:0]  empty_o;
    logic [8:0]  occ_o;
    logic        err_o;

    int          n_vec  = 0;
    int          n_miss = 0;
    logic [37:0] log_q [$];
    logic [1:0]  exp_first_vc;
    logic [33:0] exp_first_d;
    logic [1:0]  exp_second_vc;
    logic [33:0] exp_second_d;

    always #5 clk = ~clk;

    vc_input_datapath_pkt dut (
        .clk          (clk),
        .arst         (arst),
        .fin_fdata_i  (fin_fdata_i),
        .fin_type_i   (fin_type_i),
        .fin_vc_i     (fin_vc_i),
        .fin_valid_i  (fin_valid_i),
        .fin_ready_o  (fin_ready_o),
        .fout_fdata_o (fout_fdata_o),
        .fout_type_o  (fout_type_o),
        .fout_vc_o    (fout_vc_o),
        .fout_valid_o (fout_valid_o),
        .fout_ready_i (fout_ready_i),
        .full_o       (full_o),
        .empty_o      (empty_o),
        .occ_o        (occ_o),
        .err_o        (err_o)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock: drive inputs at the falling edge, log any output handshake
    task automatic drive(input logic v, input logic [1:0] vc, input logic [1:0] typ,
                         input logic [33:0] d, input logic rdy);
        @(negedge clk);
        fin_valid_i  = v;
        fin_vc_i     = vc;
        fin_type_i   = typ;
        fin_fdata_i  = d;
        fout_ready_i = rdy;
        #1;
        if (fout_valid_o && fout_ready_i) log_q.push_back({fout_vc_o, fout_type_o, fout_fdata_o});
    endtask

    task automatic do_reset();
        @(negedge clk);
        arst         = 1'b1;
        fin_valid_i  = 1'b0;
        fout_ready_i = 1'b0;
        repeat (2) @(negedge clk);
        arst = 1'b0;
        log_q.delete();
    endtask

    initial begin
        arst = 1'b1;
        fin_fdata_i = 34'h0; fin_type_i = 2'd0; fin_vc_i = 2'd0;
        fin_valid_i = 1'b0; fout_ready_i = 1'b0;

        // Reset then idle
        do_reset();
        #1;
        chk("rst_empty", 64'(empty_o), 64'h7);
        chk("rst_occ",   64'(occ_o),   64'h0);
        chk("rst_full",  64'(full_o),  64'h0);
        chk("rst_valid", 64'(fout_valid_o), 64'h0);
        chk("rst_ready", 64'(fin_ready_o),  64'h1);
        chk("rst_err",   64'(err_o), 64'h0);

        // Fill VC1 with output stalled
        for (int i = 0; i < 4; i++) drive(1'b1, 2'd1, T_BODY, 34'h100 + 34'(i), 1'b0);
        drive(1'b1, 2'd1, T_BODY, 34'h1ff, 1'b0);
        chk("fill_rdy_vc1", 64'(fin_ready_o), 64'h0);
        chk("fill_occ1",    64'(occ_o[5:3]),  64'h4);
        chk("fill_full",    64'(full_o),      64'h2);
        chk("fill_empty",   64'(empty_o),     64'h5);
        chk("fill_head",    64'(fout_fdata_o), 64'h100);
        chk("fill_vc",      64'(fout_vc_o),    64'h1);
        fin_vc_i = 2'd0;
        #1;
        chk("fill_rdy_vc0", 64'(fin_ready_o), 64'h1);
        fin_valid_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'd0, T_BODY, 34'h0, 1'b1);
            chk("drain_data", 64'(fout_fdata_o), 64'h100 + 64'(i));
        end
        drive(1'b0, 2'd0, T_BODY, 34'h0, 1'b0);
        chk("drain_empty", 64'(empty_o), 64'h7);
        chk("drain_valid", 64'(fout_valid_o), 64'h0);

        // Pointer wrap plus simultaneous push/pop on VC1
        drive(1'b1, 2'd1, T_BODY, 34'h104, 1'b0);
        drive(1'b1, 2'd1, T_BODY, 34'h105, 1'b0);
        drive(1'b1, 2'd1, T_BODY, 34'h106, 1'b1);
        chk("wrap_head", 64'(fout_fdata_o), 64'h104);
        drive(1'b0, 2'd0, T_BODY, 34'h0, 1'b0);
        chk("pushpop_occ", 64'(occ_o[5:3]), 64'h2);
        chk("wrap_next",   64'(fout_fdata_o), 64'h105);
        drive(1'b0, 2'd0, T_BODY, 34'h0, 1'b1);
        drive(1'b0, 2'd0, T_BODY, 34'h0, 1'b1);
        chk("wrap_last", 64'(fout_fdata_o), 64'h106);

        // Output stays stable while stalled even if a higher priority VC fills
        do_reset();
        drive(1'b1, 2'd2, T_HT, 34'h0a5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 2'd0, T_BODY, 34'h0, 1'b0);
            chk("hold_data", 64'(fout_fdata_o), 64'h0a5);
        end
        drive(1'b1, 2'd0, T_HT, 34'h011, 1'b0);
        drive(1'b0, 2'd0, T_BODY, 34'h0, 1'b0);
        chk("hold_vc",   64'(fout_vc_o),    64'h2);
        chk("hold_data2", 64'(fout_fdata_o), 64'h0a5);
        drive(1'b0, 2'd0, T_BODY, 34'h0, 1'b1);
        chk("hold_pop", 64'(fout_fdata_o), 64'h0a5);
        drive(1'b0, 2'd0, T_BODY, 34'h0, 1'b0);
        chk("hold_after_vc", 64'(fout_vc_o),    64'h0);
        chk("hold_after_d",  64'(fout_fdata_o), 64'h011);

        // Packet lock: VC1 must wait behind VC0's HEAD..TAIL
        do_reset();
        drive(1'b1, 2'd0, T_HEAD, 34'h010, 1'b1);
        drive(1'b1, 2'd1, T_HT,   34'h021, 1'b1);
        drive(1'b1, 2'd0, T_BODY, 34'h011, 1'b1);
        chk("lock_block", 64'(fout_valid_o), 64'h0);
        drive(1'b1, 2'd0, T_TAIL, 34'h012, 1'b1);
        for (int i = 0; i < 3; i++) drive(1'b0, 2'd0, T_BODY, 34'h0, 1'b1);
        chk("lock_cnt", 64'(log_q.size()), 64'h4);
        chk("lock_0", 64'(log_q[0]), 64'({2'd0, T_HEAD, 34'h010}));
        chk("lock_1", 64'(log_q[1]), 64'({2'd0, T_BODY, 34'h011}));
        chk("lock_2", 64'(log_q[2]), 64'({2'd0, T_TAIL, 34'h012}));
        chk("lock_3", 64'(log_q[3]), 64'({2'd1, T_HT,   34'h021}));

        // Priority: VC0 and VC2 wait behind a VC0 packet, pointer ends at 1
        do_reset();
        drive(1'b1, 2'd0, T_HEAD, 34'h040, 1'b1);
        drive(1'b0, 2'd0, T_BODY, 34'h0,   1'b1);
        drive(1'b1, 2'd0, T_TAIL, 34'h041, 1'b0);
        drive(1'b1, 2'd0, T_HT,   34'h050, 1'b0);
        drive(1'b1, 2'd2, T_HT,   34'h052, 1'b0);
        drive(1'b0, 2'd0, T_BODY, 34'h0,   1'b1);
        drive(1'b0, 2'd0, T_BODY, 34'h0,   1'b0);
`ifdef RAVENOC_RR_ARB_EN
        exp_first_vc = 2'd2; exp_first_d = 34'h052;
        exp_second_vc = 2'd0; exp_second_d = 34'h050;
`else
        exp_first_vc = 2'd0; exp_first_d = 34'h050;
        exp_second_vc = 2'd2; exp_second_d = 34'h052;
`endif
        chk("prio_vc", 64'(fout_vc_o), 64'(exp_first_vc));
        drive(1'b0, 2'd0, T_BODY, 34'h0, 1'b1);
        drive(1'b0, 2'd0, T_BODY, 34'h0, 1'b1);
        chk("prio_cnt", 64'(log_q.size()), 64'h4);
        chk("prio_tail",   64'(log_q[1]), 64'({2'd0, T_TAIL, 34'h041}));
        chk("prio_first",  64'(log_q[2]), 64'({exp_first_vc,  T_HT, exp_first_d}));
        chk("prio_second", 64'(log_q[3]), 64'({exp_second_vc, T_HT, exp_second_d}));

        // Illegal VC id: accepted, dropped, sticky error
        do_reset();
        drive(1'b1, 2'd3, T_HT, 34'h077, 1'b0);
        chk("ill_ready", 64'(fin_ready_o), 64'h1);
        chk("ill_err0",  64'(err_o), 64'h0);
        drive(1'b0, 2'd0, T_BODY, 34'h0, 1'b0);
        chk("ill_err1",  64'(err_o),   64'h1);
        chk("ill_occ",   64'(occ_o),   64'h0);
        chk("ill_empty", 64'(empty_o), 64'h7);
        for (int i = 0; i < 3; i++) drive(1'b0, 2'd0, T_BODY, 34'h0, 1'b0);
        chk("ill_sticky", 64'(err_o), 64'h1);
        chk("ill_valid",  64'(fout_valid_o), 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/vc_input_datapath_pkt.md
Name: vc_input_datapath_pkt

Overview:
Parametrised next-generation router input datapath: one flit input port is demultiplexed by VC id into NumVc independent circular FIFOs. Up to NumVc non-empty VCs then compete for a single flit output port.
- Arbitration is fixed-priority or round-robin.
- Grant granularity is per flit or per packet (wormhole lock from head to tail).
- Once presented, output flits stay stable until accepted.
- Exports per-VC full/empty/occupancy for credit logic in the upstream output module.
- Sits between the link input and the router crossbar/output module.

Parameters:
- NumVc, 3, number of virtual channels (2..8).
- VcDepth, 4, flits per VC FIFO; power of two, minimum 2.
- FlitWidth, 34, flit payload width in bits.
- PktArb, 1, 1 = hold grant from head to tail flit; 0 = re-arbitrate every flit.
- HighPrioZero, 1, fixed-priority mode: 1 = VC0 highest, 0 = VC(NumVc-1) highest.

Ports:
- clk  in  1  clock
- arst  in  1  reset, synchronous, active-high (one clock; polarity and synchronicity fixed)
- fin_fdata_i  in  FlitWidth  input flit payload
- fin_type_i  in  2  flit type: 0 HEAD, 1 BODY, 2 TAIL, 3 HEAD_TAIL
- fin_vc_i  in  VcW=$clog2(NumVc)  target VC
- fin_valid_i  in  1  input valid
- fin_ready_o  out  1  input ready
- fout_fdata_o  out  FlitWidth  output flit payload
- fout_type_o  out  2  output flit type
- fout_vc_o  out  VcW  VC of output flit
- fout_valid_o  out  1  output valid
- fout_ready_i  in  1  output ready
- full_o  out  NumVc  per-VC full
- empty_o  out  NumVc  per-VC empty
- occ_o  out  NumVc*OccW  per-VC occupancy, OccW=$clog2(VcDepth+1); VC i in bits [i*OccW +: OccW]
- err_o  out  1  sticky illegal-VC error

Behaviour:
- Reset values: FIFO pointers and counters 0, so empty_o all 1, full_o 0, occ_o 0. fout_valid_o 0. Grant register 0. FSM IDLE. Round-robin pointer 0. err_o 0.
- Reset mid-packet discards all buffered flits and any lock.
- Input ready: fin_ready_o = ~full[fin_vc_i] when fin_valid_i=1 and fin_vc_i<NumVc; otherwise 1.
- Input push: occurs when fin_valid_i & fin_ready_o.
- Illegal VC: fin_valid_i with fin_vc_i>=NumVc is accepted and dropped, and err_o sets until reset.
- FIFOs: no bypass, so a flit pushed at cycle N is visible at the output no earlier than N+1.
- Push and pop on the same VC in the same cycle: occupancy unchanged.
- A full VC cannot push, because ready is low, even if it is popped that cycle.
- Pointers wrap modulo VcDepth.
- Occupancy is an up/down counter saturating at 0..VcDepth; full = (occ==VcDepth), empty = (occ==0).
- Output stability: while fout_valid_o=1 and fout_ready_i=0, fout_* and the grant are held unchanged.
- Pop: occurs on fout_valid_o & fout_ready_i, from the granted VC.
- Arbitration: evaluated combinationally from the non-empty set only when not holding. The grant is registered at handshake so stability is kept.
- FSM IDLE: arbitrate among non-empty VCs and present the winner.
  - On handshake of a HEAD flit with PktArb=1, go to LOCK(vc).
  - On HEAD_TAIL, or with PktArb=0, stay in IDLE.
- FSM LOCK(vc): only that VC may be presented; other VCs wait even if non-empty.
  - fout_valid_o = ~empty[vc].
  - On handshake of a TAIL flit, return to IDLE.
- Protocol violations: a HEAD seen while LOCK on the same VC is forwarded and keeps the lock, with no error; the upstream protocol guarantees ordering.
- Round-robin: pointer moves to granted VC+1 (mod NumVc) on each IDLE grant handshake.

Optional Feature:
- Macro RAVENOC_RR_ARB_EN.
- Defined: IDLE arbitration is round-robin starting at the pointer, and HighPrioZero is ignored.
- Undefined: fixed priority per HighPrioZero, with no pointer register.
- Lock and stability rules are identical in both modes.

Decomposition:
- Shared package (ravenoc_pkg): flit-type enum (HEAD/BODY/TAIL/HEAD_TAIL), VcW/OccW helper functions, arbiter FSM state enum.
- Sub-module vc_circ_fifo: single VC FIFO with pointers, occupancy counter, full/empty; instantiated NumVc times in a generate loop.
- Top level holds the demux, arbiter FSM and output mux.

Test Plan:
- Reset then idle: arst=1 for 2 cycles, then arst=0 -> empty_o=3'b111, occ_o=0, fout_valid_o=0, fin_ready_o=1, err_o=0.
- Fill VC1: push 4 flits to VC1 with fout_ready_i=0 -> occ VC1=4, full_o[1]=1, fin_ready_o=0 for vc1, fin_ready_o=1 for vc0.
- Hold-stable: VC2 flit 0xA5 presented with fout_ready_i=0 for 5 cycles, then a push to VC0 -> fout_fdata_o stays 0xA5 on VC2 until ready.
- Packet lock (PktArb=1): VC0 HEAD,BODY,TAIL interleaved in time with VC1 HEAD_TAIL -> output order VC0 HEAD/BODY/TAIL, then VC1.
- Fixed priority, macro undefined, HighPrioZero=1: VC0 and VC2 both HEAD_TAIL pending -> VC0 first. With RAVENOC_RR_ARB_EN defined and pointer at 1 -> VC2 first.
- Illegal VC: fin_vc_i=3 (NumVc=3) with valid -> fin_ready_o=1, no occupancy change, err_o=1 next cycle and held.
